// File: rtl/nibble_frame_tx.sv
// Buffers one payload of nibbles and sends it as preamble/SFD header, payload and reflected CRC-32.
// Frame runs back-to-back from one start request; writes and starts are ignored while busy.
module nibble_frame_tx #(
   parameter int         PAYLOAD_LEN = 30,
   parameter int         HDR_LEN     = 16,
   parameter logic [3:0] PRE_NIB     = 4'h5,
   parameter logic [3:0] SFD_NIB     = 4'hD
) (
   input  logic       i_clk_125m,
   input  logic       i_rst,
   input  logic       i_wr_en,
   input  logic [3:0] i_wr_data,
   output logic       o_wr_ready,
   input  logic       i_start,
   output logic       o_irq,
   output logic [3:0] o_tx_data,
   output logic       o_tx_valid,
   output logic       o_busy,
   output logic       o_done
);

   localparam int         AW       = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
   localparam logic [5:0] PAY_LEN6 = 6'(PAYLOAD_LEN);
   localparam logic [5:0] PAY_LAST = 6'(PAYLOAD_LEN - 1);
   localparam logic [5:0] HDR_LAST = 6'(HDR_LEN - 1);
   localparam logic [5:0] CRC_LAST = 6'd7;

   typedef enum logic [2:0] {
      S_IDLE,
      S_IRQ,
      S_HDR,
      S_DATA,
      S_CRC,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [5:0]  count_q, count_d;
   logic [5:0]  idx_q, idx_d;
   logic [31:0] crc_q, crc_d;
   logic [3:0]  pay_mem [PAYLOAD_LEN];

   logic        wr_ok;
   logic [4:0]  crc_base;
   logic [3:0]  crc_sel;
   logic [3:0]  tx_data_d;
   logic        tx_valid_d;

   // Reflected CRC-32, data bit 0 consumed first.
   function automatic logic [31:0] crc4(input logic [31:0] c_in, input logic [3:0] d);
      logic [31:0] c;
      c = c_in;
      for (int i = 0; i < 4; i++) begin
         if (c[0] ^ d[i]) c = (c >> 1) ^ 32'hEDB88320;
         else             c = c >> 1;
      end
      return c;
   endfunction

   assign wr_ok = (state_q == S_IDLE) && (count_q < PAY_LEN6);

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      idx_d   = idx_q;
      crc_d   = crc_q;
      case (state_q)
         S_IDLE: begin
            if (wr_ok && i_wr_en) begin
               count_d = count_q + 6'd1;
               crc_d   = crc4(crc_q, i_wr_data);
            end
            // Start is judged on the pre-write count, so it cannot ride on the last write.
            if (i_start && (count_q == PAY_LEN6)) state_d = S_IRQ;
         end
         S_IRQ: begin
            state_d = S_HDR;
            idx_d   = '0;
         end
         S_HDR: begin
            if (idx_q == HDR_LAST) begin
               state_d = S_DATA;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + 6'd1;
            end
         end
         S_DATA: begin
            if (idx_q == PAY_LAST) begin
               state_d = S_CRC;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + 6'd1;
            end
         end
         S_CRC: begin
            if (idx_q == CRC_LAST) begin
               state_d = S_DONE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + 6'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            count_d = '0;
            crc_d   = '1;
            idx_d   = '0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are registered from next-state values so they line up with the state they describe.
   always_comb begin
      tx_data_d  = 4'h0;
      tx_valid_d = 1'b0;
      crc_base   = 5'd28 - {idx_d[2:0], 2'b00};
      crc_sel    = crc_q[crc_base +: 4];
      case (state_d)
         S_HDR: begin
            tx_valid_d = 1'b1;
            tx_data_d  = (idx_d == HDR_LAST) ? SFD_NIB : PRE_NIB;
         end
         S_DATA: begin
            tx_valid_d = 1'b1;
            tx_data_d  = pay_mem[idx_d[AW-1:0]];
         end
         S_CRC: begin
            tx_valid_d = 1'b1;
            tx_data_d  = {crc_sel[0], crc_sel[1], crc_sel[2], crc_sel[3]};
         end
         default: begin
            tx_valid_d = 1'b0;
            tx_data_d  = 4'h0;
         end
      endcase
   end

   always_ff @(posedge i_clk_125m) begin
      if (i_rst) begin
         state_q    <= S_IDLE;
         count_q    <= '0;
         idx_q      <= '0;
         crc_q      <= '1;
         o_irq      <= 1'b0;
         o_tx_data  <= 4'h0;
         o_tx_valid <= 1'b0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
         o_wr_ready <= 1'b1;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         idx_q      <= idx_d;
         crc_q      <= crc_d;
         o_irq      <= (state_d == S_IRQ);
         o_tx_data  <= tx_data_d;
         o_tx_valid <= tx_valid_d;
         o_busy     <= (state_d != S_IDLE);
         o_done     <= (state_d == S_DONE);
         o_wr_ready <= (state_d == S_IDLE) && (count_d < PAY_LEN6);
      end
   end

   // Payload storage has no reset; a frame only ever reads entries written since the last clear.
   always_ff @(posedge i_clk_125m) begin
      if (!i_rst && wr_ok && i_wr_en) pay_mem[count_q[AW-1:0]] <= i_wr_data;
   end

endmodule

// File: doc/nibble_frame_tx.md
NIBBLE_FRAME_TX -- requirements
Module: nibble_frame_tx

Interface
REQ-001 Parameter PAYLOAD_LEN, default 30, is the number of payload nibbles per frame.
REQ-002 Parameter HDR_LEN, default 16, is the number of header nibbles per frame.
REQ-003 Parameter PRE_NIB, default 4'h5, is the header fill nibble.
REQ-004 Parameter SFD_NIB, default 4'hD, is the last header nibble.
REQ-005 i_clk_125m  input  1  single clock; all logic on its rising edge.
REQ-006 i_rst  input  1  reset, synchronous and active-high.
REQ-007 i_wr_en  input  1  payload nibble write strobe.
REQ-008 i_wr_data  input  4  payload nibble.
REQ-009 o_wr_ready  output  1  high when a write will be accepted.
REQ-010 i_start  input  1  request to transmit the buffered frame.
REQ-011 o_irq  output  1  one-cycle frame-start pulse to the downstream receiver.
REQ-012 o_tx_data  output  4  serial nibble stream.
REQ-013 o_tx_valid  output  1  o_tx_data carries a frame nibble this cycle.
REQ-014 o_busy  output  1  frame transmission in progress.
REQ-015 o_done  output  1  one-cycle pulse after the last CRC nibble.

Function
REQ-016 The block SHALL hold a PAYLOAD_LEN x 4-bit buffer, a 6-bit fill count, a 32-bit CRC register, and the states IDLE, IRQ, HDR, DATA, CRC, DONE.
REQ-017 o_wr_ready SHALL equal (state==IDLE && count<PAYLOAD_LEN); a write is accepted only when i_wr_en && o_wr_ready, storing at index count and incrementing count.
REQ-018 Writes with o_wr_ready low SHALL be ignored, with no change to the buffer, count, or CRC.
REQ-019 On each accepted write, the CRC register SHALL advance by 4 bits of reflected CRC-32 (polynomial 0xEDB88320), consuming i_wr_data bit 0 first.
REQ-020 The CRC register initial value SHALL be 32'hFFFFFFFF; no final XOR is applied.
REQ-021 IDLE->IRQ SHALL occur when i_start is high and count==PAYLOAD_LEN (count sampled before any same-cycle write); otherwise i_start SHALL be ignored.
REQ-022 Accepting i_start on the cycle of the last write SHALL be impossible; because count is PAYLOAD_LEN-1 in that cycle, the start is ignored and the write is accepted.
REQ-023 In IRQ, o_irq SHALL be 1 for exactly one cycle and o_tx_valid SHALL be 0; the next state is HDR.
REQ-024 In HDR, the block SHALL emit HDR_LEN nibbles: HDR_LEN-1 times PRE_NIB, then SFD_NIB.
REQ-025 In DATA, the block SHALL emit buffer[0]..buffer[PAYLOAD_LEN-1] in order, one per cycle.
REQ-026 In CRC, the block SHALL emit 8 nibbles; nibble k (k=0..7) is {C[28-4k],C[29-4k],C[30-4k],C[31-4k]} (MSB..LSB of the nibble), where C is the CRC register.
REQ-027 The CRC register SHALL NOT change between acceptance of i_start and the end of the CRC state.
REQ-028 o_tx_valid SHALL be 1 in every HDR, DATA, and CRC cycle and 0 otherwise; o_tx_data SHALL be 4'h0 whenever o_tx_valid is 0.
REQ-029 o_busy SHALL be 1 in the IRQ, HDR, DATA, CRC, and DONE states.
REQ-030 In DONE, o_done SHALL be 1 for one cycle, count SHALL clear to 0, the CRC register SHALL reload to 32'hFFFFFFFF, and the next state is IDLE.
REQ-031 Timing: i_start accepted at cycle T -> o_irq at T+1 -> o_tx_valid high T+2..T+55 (54 nibbles) -> o_done at T+56 -> o_wr_ready high again at T+57.
REQ-032 i_wr_en and i_start SHALL have no effect while o_busy is 1.
REQ-033 All outputs SHALL be registered; the frame runs back-to-back with no gaps between nibbles.

Reset
REQ-034 While i_rst is high at a clock edge, the block SHALL enter IDLE, set count=0 and CRC=32'hFFFFFFFF, and drive o_irq, o_tx_valid, o_busy, and o_done to 0 and o_tx_data to 4'h0; o_wr_ready is then 1.
REQ-035 Reset asserted mid-frame SHALL abort the frame immediately, with no further o_tx_valid or o_done; buffer contents need not be cleared.

Verification
REQ-036 Load nibbles 0..29 as (i mod 16), then pulse i_start -> o_irq 1 cycle; then 15x4'h5, 4'hD, the payload in order, and 8 CRC nibbles equal to a nibble-wise reflected CRC-32 model (init FFFFFFFF, no XOR out), all bit-ordered per REQ-026.
REQ-037 Pulse i_start after 29 writes -> no o_irq; write the 30th nibble and then pulse i_start -> frame starts at T+1.
REQ-038 Attempt a 31st write and writes during o_busy -> all ignored; the transmitted payload and CRC are unchanged from the 30-write case.
REQ-039 Drive i_wr_en (30th nibble) and i_start in the same cycle -> write accepted, no o_irq; i_start on the next cycle -> frame starts.
REQ-040 Assert i_rst for 1 cycle during the DATA state -> o_tx_valid 0 the next cycle, no o_done, o_wr_ready 1, count 0; a new 30-nibble load then produces a correct frame.
REQ-041 Send two consecutive frames with different payloads -> the second frame's CRC is computed from 32'hFFFFFFFF, with no carry-over from the first.
